// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg -- shared definitions for the systolic-array result path.
//
// Contents:
//   SA_DATA_WIDTH / SA_NUM_COLS / SA_FIFO_DEPTH : default geometry
//   sa_state_e                                  : result collector FSM states
// -----------------------------------------------------------------------------
package sa_pkg;

    localparam int unsigned SA_DATA_WIDTH = 16;
    localparam int unsigned SA_NUM_COLS   = 4;
    localparam int unsigned SA_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } sa_state_e;

endpackage : sa_pkg

// File: rtl/sa_row_fifo.sv
// -----------------------------------------------------------------------------
// sa_row_fifo -- synchronous FIFO holding whole result rows.
//
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   push, push_data  : write request and row; ignored when full unless a pop
//                      happens in the same cycle
//   pop, pop_data    : read request (ignored when empty) and head entry
//   full, empty      : occupancy flags
//   count            : number of stored rows (0..DEPTH)
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module sa_row_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone defines which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule : sa_row_fifo

// File: rtl/sa_result_collector.sv
// -----------------------------------------------------------------------------
// sa_result_collector -- deskews the bottom-row outputs of a systolic array,
// assembles complete result rows and buffers them for a ready/valid consumer.
//
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   start, num_rows      : frame start pulse (IDLE only) and expected rows
//                          (0 is treated as 1)
//   col_data, col_valid  : per-column results; column c lags column 0 by c
//   out_data, out_valid  : head row of the buffer, out_ready accepts it
//   stall                : asks the array to pause while the buffer is near full
//   busy, done           : frame active / one-cycle frame-drained pulse
//   err                  : sticky {overflow, skew mismatch}
//
// Build option: define SA_COLLECTOR_ERR_CHECK_EN to enable the err flags;
// otherwise err is tied to 2'b00 and the checking logic is not built.
// -----------------------------------------------------------------------------
module sa_result_collector
    import sa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SA_DATA_WIDTH,
    parameter int unsigned NUM_COLS   = SA_NUM_COLS,
    parameter int unsigned FIFO_DEPTH = SA_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [7:0]                     num_rows,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] col_data,
    input  logic [NUM_COLS-1:0]            col_valid,
    output logic [NUM_COLS*DATA_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           stall,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     err
);

    localparam int unsigned ROW_W = NUM_COLS * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    // Leave room for the rows already travelling through the skew lines.
    localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(FIFO_DEPTH - NUM_COLS);

    sa_state_e        state_q, state_d;
    logic [7:0]       rows_written_q, rows_written_d;
    logic [7:0]       num_rows_q, num_rows_d;

    logic [DATA_WIDTH-1:0] dly_data [NUM_COLS];
    logic [NUM_COLS-1:0]   dly_valid;
    logic [ROW_W-1:0]      row_data;
    logic                  row_aligned;
    logic                  wr_en;

    logic [ROW_W-1:0] fifo_head;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // ------------------------------------------------------------------
    // Deskew: column c waits NUM_COLS-1-c cycles so every column of a row
    // reaches the aligned point in the same cycle as the last column.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        localparam int STAGES = int'(NUM_COLS) - 1 - c;

        if (STAGES == 0) begin : g_pass
            assign dly_data[c]  = col_data[c*DATA_WIDTH +: DATA_WIDTH];
            assign dly_valid[c] = col_valid[c];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] data_q [STAGES];
            logic [DATA_WIDTH-1:0] data_d [STAGES];
            logic [STAGES-1:0]     valid_q, valid_d;

            always_comb begin
                data_d     = data_q;
                valid_d    = valid_q;
                data_d[0]  = col_data[c*DATA_WIDTH +: DATA_WIDTH];
                valid_d[0] = col_valid[c];
                for (int k = 1; k < STAGES; k++) begin
                    data_d[k]  = data_q[k-1];
                    valid_d[k] = valid_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
                    valid_q <= '0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign dly_data[c]  = data_q[STAGES-1];
            assign dly_valid[c] = valid_q[STAGES-1];
        end
    end

    always_comb begin
        row_data = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            row_data[c*DATA_WIDTH +: DATA_WIDTH] = dly_data[c];
        end
    end

    assign row_aligned = &dly_valid;
    assign wr_en       = row_aligned && (state_q == ST_COLLECT);

    // ------------------------------------------------------------------
    // Frame control
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        rows_written_d = rows_written_q;
        num_rows_d     = num_rows_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_COLLECT;
                    rows_written_d = '0;
                    num_rows_d     = (num_rows == 8'd0) ? 8'd1 : num_rows;
                end
            end
            ST_COLLECT: begin
                if (rows_written_q == num_rows_q) state_d = ST_DRAIN;
                // Rows dropped on overflow still count, so the frame always ends.
                if (wr_en) rows_written_d = rows_written_q + 8'd1;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            rows_written_q <= '0;
            num_rows_q     <= 8'd1;
        end else begin
            state_q        <= state_d;
            rows_written_q <= rows_written_d;
            num_rows_q     <= num_rows_d;
        end
    end

    // ------------------------------------------------------------------
    // Row buffer and output side
    // ------------------------------------------------------------------
    assign fifo_pop = out_valid && out_ready;

    sa_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (row_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    // Gating keeps out_data at zero whenever nothing is buffered, including reset.
    assign out_data  = fifo_empty ? '0 : fifo_head;
    assign stall     = (fifo_count >= STALL_LEVEL);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DRAIN) && fifo_empty;

    // ------------------------------------------------------------------
    // Optional sticky error flags
    // ------------------------------------------------------------------
`ifdef SA_COLLECTOR_ERR_CHECK_EN
    logic [1:0] err_q, err_d;
    logic       skew_mismatch, row_dropped;

    assign skew_mismatch = (state_q == ST_COLLECT) && (|dly_valid) && !row_aligned;
    assign row_dropped   = wr_en && fifo_full && !fifo_pop;

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && start) begin
            err_d = 2'b00;
        end else begin
            if (skew_mismatch) err_d[0] = 1'b1;
            if (row_dropped)   err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 2'b00;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;
    assign err = 2'b00;
`endif

endmodule : sa_result_collector

// File: doc/sa_result_collector.md
SA_RESULT_COLLECTOR -- requirements
Module: sa_result_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one column partial sum.
REQ-002 SHALL have parameter NUM_COLS, default 4: number of array columns collected.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: row entries buffered; power of two, at least 2*NUM_COLS.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-007 SHALL have port num_rows, input, 8: rows expected in the frame; latched on an accepted start; 0 is treated as 1.
REQ-008 SHALL have port col_data, input, NUM_COLS*DATA_WIDTH: bottom-row PE out_down values; column c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port col_valid, input, NUM_COLS: per-column valid; column c is skewed c cycles behind column 0.
REQ-010 SHALL have port out_data, output, NUM_COLS*DATA_WIDTH: deskewed result row, column-packed as col_data.
REQ-011 SHALL have port out_valid, output, 1: out_data holds a row.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts; a row transfers when out_valid and out_ready are both high.
REQ-013 SHALL have port stall, output, 1: array must pause its feeder.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when the frame fully drains.
REQ-016 SHALL have port err, output, 2: sticky flags; bit0 = skew mismatch, bit1 = overflow.

Function
REQ-017 SHALL delay column c by NUM_COLS-1-c cycles, data and valid together, so that all columns of a row align.
REQ-018 SHALL write an aligned row to the FIFO in the cycle where all delayed valids are high, in state COLLECT only.
REQ-019 SHALL implement FSM states IDLE, COLLECT and DRAIN.
REQ-020 SHALL transition IDLE->COLLECT on start; rows_written clears and num_rows latches.
REQ-021 SHALL transition COLLECT->DRAIN in the cycle after rows_written reaches the latched num_rows.
REQ-022 SHALL transition DRAIN->IDLE when the FIFO is empty, and pulse done for one cycle in that transition cycle.
REQ-023 SHALL ignore aligned rows arriving in IDLE or DRAIN; no write, no count.
REQ-024 SHALL drive out_valid whenever the FIFO is non-empty; out_data = head entry; latency from aligned write to out_valid = 1 cycle.
REQ-025 SHALL allow a simultaneous push and pop; the count stays unchanged, including when the FIFO is full.
REQ-026 SHALL assert stall combinationally while FIFO count >= FIFO_DEPTH-NUM_COLS, giving slack for in-flight skewed rows.
REQ-027 SHALL drop a row written while the FIFO is full without a same-cycle pop; FIFO contents SHALL be unchanged.
REQ-028 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-029 SHALL pass data unmodified; no arithmetic on col_data.

Reset
REQ-030 SHALL, on reset low, immediately clear: state=IDLE, FIFO empty, pointers=0, delay lines invalid, rows_written=0, err=0.
REQ-031 SHALL hold outputs out_valid=0, stall=0, busy=0, done=0 and out_data=0 while reset is low.
REQ-032 SHALL discard any frame in progress when reset asserts mid-operation, with no done pulse.

Configuration
REQ-033 SHALL, with macro SA_COLLECTOR_ERR_CHECK_EN defined, set err[0] when delayed valids disagree in COLLECT and set err[1] on a dropped row; flags clear only by reset or start.
REQ-034 SHALL, without SA_COLLECTOR_ERR_CHECK_EN, tie err to 2'b00 and omit the checking logic; data behaviour is identical.

Structure
REQ-035 SHALL take the FSM state enum and DATA_WIDTH/NUM_COLS defaults from shared package sa_pkg.
REQ-036 SHALL implement the FIFO as sub-module sa_row_fifo, with push, pop, full, empty and count.

Verification
REQ-037 SHALL verify: NUM_COLS=4, num_rows=3, rows {1,2,3,4},{5,6,7,8},{9,10,11,12} fed skewed, out_ready=1 -> three rows out in order, then done pulse, busy low.
REQ-038 SHALL verify: out_ready=0 while feeding 8 rows -> stall rises at count 4, no row lost, err=0 after draining.
REQ-039 SHALL verify: col_valid[2] dropped for one cycle mid-row -> that row not written, err[0]=1 (macro on), err=0 (macro off).
REQ-040 SHALL verify: FIFO full, stall ignored, one more row -> row dropped, err[1]=1, contents intact.
REQ-041 SHALL verify: reset pulsed during COLLECT with 2 rows buffered -> out_valid=0 immediately, state IDLE, no done.
REQ-042 SHALL verify: full FIFO with push and pop in the same cycle -> count stays 8 and ordering is preserved.
